// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_pkg
// Brief    : Shared state encoding and default geometry for the SRAM burst
//            controller.
// Revision : 1.0
// ============================================================================
package sram_ctrl_pkg;

    localparam int c_DEF_A = 7;
    localparam int c_DEF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : sram_out_stage
// Brief    : Single-entry read output register with valid/ready handshake.
// Revision : 1.0
// ============================================================================
module sram_out_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_fetch_avail,
    input  logic [W-1:0] i_sram_data,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data,
    output logic         o_out_valid,
    output logic         o_fetch,
    output logic         o_xfer
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;

    // Refill whenever the slot is empty or is being drained this cycle.
    assign o_fetch     = i_fetch_avail && (!valid_q || i_out_ready);
    assign o_xfer      = valid_q && i_out_ready;
    assign o_out_data  = data_q;
    assign o_out_valid = valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (o_fetch) begin
            data_d  = i_sram_data;
            valid_d = 1'b1;
        end else if (o_xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_burst_ctrl
// Brief    : Streams write bursts into, and read bursts out of, an external
//            single-port SRAM with combinational read data.
// Revision : 1.0
// ============================================================================
module sram_burst_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int A = c_DEF_A,
    parameter int W = c_DEF_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic         mode,
    input  logic [A-1:0] base,
    input  logic [A:0]   length,
    output logic         busy,
    output logic         done,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [A-1:0] sram_address,
    output logic [W-1:0] sram_dataInput,
    output logic         sram_write,
    input  logic [W-1:0] sram_dataOutput
);

    localparam logic [A:0] c_CNT_ONE = {{A{1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [A:0]   count_q, count_d;
    logic [A:0]   len_q, len_d;
    logic [A-1:0] base_q, base_d;

    logic         w_fetch;
    logic         w_xfer;
    logic         w_all_fetched;
    logic         w_fetch_avail;
    logic [A:0]   w_last_idx;

    assign w_last_idx    = len_q - c_CNT_ONE;
    assign w_all_fetched = (count_q == len_q);
    assign w_fetch_avail = (state_q == ST_READ) && !w_all_fetched;

    // Low A bits of the counter give natural wrap past the top address.
    assign sram_address   = base_q + count_q[A-1:0];
    assign sram_dataInput = in_data;
    assign in_ready       = (state_q == ST_WRITE);
    assign sram_write     = in_ready && in_valid;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);

    sram_out_stage #(
        .W (W)
    ) u_out_stage (
        .clk           (CLK),
        .rst           (RST),
        .i_fetch_avail (w_fetch_avail),
        .i_sram_data   (sram_dataOutput),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_out_valid   (out_valid),
        .o_fetch       (w_fetch),
        .o_xfer        (w_xfer)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        base_d  = base_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base;
                    len_d   = length;
                    count_d = '0;
                    if (length == '0) begin
                        state_d = ST_DONE;
                    end else if (mode) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (in_valid) begin
                    count_d = count_q + c_CNT_ONE;
                    if (count_q == w_last_idx) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (w_fetch) begin
                    count_d = count_q + c_CNT_ONE;
                end
                // With every word fetched, the buffered word is the final one.
                if (w_xfer && w_all_fetched) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            len_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            base_q  <= base_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_burst_ctrl
// Brief    : Self-checking bench for sram_burst_ctrl with a behavioural SRAM
//            and a burst-level reference model.
// Revision : 1.0
// ============================================================================
module tb_sram_burst_ctrl;

    localparam int A     = 7;
    localparam int W     = 16;
    localparam int DEPTH = 1 << A;

    logic         CLK;
    logic         RST;
    logic         start;
    logic         mode;
    logic [A-1:0] base;
    logic [A:0]   length;
    logic         busy;
    logic         done;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [A-1:0] sram_address;
    logic [W-1:0] sram_dataInput;
    logic [W-1:0] sram_dataOutput;
    logic         sram_write;

    logic [W-1:0]   mem       [DEPTH];
    logic [W-1:0]   model_mem [DEPTH];
    logic [A+W-1:0] wr_log    [$];
    logic [W-1:0]   rd_log    [$];
    int             done_cnt = 0;
    int             total    = 0;
    int             bad      = 0;

    sram_burst_ctrl #(
        .A (A),
        .W (W)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .start           (start),
        .mode            (mode),
        .base            (base),
        .length          (length),
        .busy            (busy),
        .done            (done),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .sram_address    (sram_address),
        .sram_dataInput  (sram_dataInput),
        .sram_write      (sram_write),
        .sram_dataOutput (sram_dataOutput)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    assign sram_dataOutput = mem[sram_address];

    always @(posedge CLK) begin
        if (sram_write) begin
            mem[sram_address] = sram_dataInput;
            wr_log.push_back({sram_address, sram_dataInput});
        end
        if (out_valid && out_ready) rd_log.push_back(out_data);
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e_val);
        total++;
        assert (obs === e_val) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e_val);
        end
    endtask

    // dbase >= 0 gives data dbase+i, otherwise random; rst_after >= 0 aborts after that many words.
    task automatic write_burst(input logic [A-1:0] b, input logic [A:0] l, input int vpct,
                               input int rst_after, input int dbase, input string tag);
        logic [W-1:0] wd [$];
        logic [A-1:0] ea [$];
        int idx, cyc, d0, n_exp, n_cmp;
        for (int i = 0; i < int'(l); i++) begin
            wd.push_back(dbase >= 0 ? W'(dbase + i) : W'($urandom));
            ea.push_back(A'((int'(b) + i) % DEPTH));
        end
        wr_log.delete();
        d0  = done_cnt;
        idx = 0;
        cyc = 0;
        @(negedge CLK);
        start = 1'b1; mode = 1'b0; base = b; length = l; in_valid = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        if (l == '0) chk({tag, "_len0_done"}, {31'd0, done}, 32'd1);
        while (!done && !(rst_after >= 0 && idx == rst_after) && cyc < 2000) begin
            in_valid = (idx < int'(l)) && (int'($urandom_range(99)) < vpct);
            in_data  = (idx < int'(l)) ? wd[idx] : '0;
            if (in_valid && in_ready) idx++;
            @(negedge CLK);
            cyc++;
        end
        in_valid = 1'b0;
        if (rst_after >= 0) begin
            RST = 1'b1;
            in_valid = 1'b1;
            #1;
            chk({tag, "_busy_rst"},   {31'd0, busy},       32'd0);
            chk({tag, "_inrdy_rst"},  {31'd0, in_ready},   32'd0);
            chk({tag, "_wr_rst"},     {31'd0, sram_write}, 32'd0);
            chk({tag, "_done_rst"},   {31'd0, done},       32'd0);
            @(negedge CLK);
            @(negedge CLK);
            RST = 1'b0;
            in_valid = 1'b0;
            n_exp = rst_after;
            chk({tag, "_no_done"}, done_cnt - d0, 32'd0);
        end else begin
            chk({tag, "_done"},       {31'd0, done},     32'd1);
            chk({tag, "_inrdy_done"}, {31'd0, in_ready}, 32'd0);
            @(negedge CLK);
            chk({tag, "_done_1cyc"},  {31'd0, done},     32'd0);
            chk({tag, "_idle"},       {31'd0, busy},     32'd0);
            chk({tag, "_done_cnt"},   done_cnt - d0,     32'd1);
            n_exp = int'(l);
        end
        chk({tag, "_nwrites"}, wr_log.size(), n_exp);
        n_cmp = (wr_log.size() < n_exp) ? wr_log.size() : n_exp;
        for (int i = 0; i < n_cmp; i++) begin
            chk({tag, "_addr"}, 32'(wr_log[i][A+W-1:W]), 32'(ea[i]));
            chk({tag, "_data"}, 32'(wr_log[i][W-1:0]),   32'(wd[i]));
        end
        for (int i = 0; i < n_exp; i++) model_mem[ea[i]] = wd[i];
    endtask

    task automatic read_burst(input logic [A-1:0] b, input logic [A:0] l, input int rpct,
                              input int stall_first, input bit poke, input string tag);
        logic [W-1:0] ev [$];
        logic [W-1:0] held;
        logic [W-1:0] first;
        bit           hold_chk;
        int           cyc, stalls, d0;
        for (int i = 0; i < int'(l); i++) ev.push_back(model_mem[(int'(b) + i) % DEPTH]);
        first = (ev.size() > 0) ? ev[0] : '0;
        rd_log.delete();
        wr_log.delete();
        d0       = done_cnt;
        stalls   = stall_first;
        cyc      = 0;
        hold_chk = 1'b0;
        held     = '0;
        @(negedge CLK);
        start = 1'b1; mode = 1'b1; base = b; length = l; out_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        if (l == '0) begin
            chk({tag, "_len0_done"}, {31'd0, done},      32'd1);
            chk({tag, "_len0_ov"},   {31'd0, out_valid}, 32'd0);
        end else begin
            chk({tag, "_lat0"}, {31'd0, out_valid}, 32'd0);
        end
        while (!done && cyc < 4000) begin
            if (hold_chk) begin
                chk({tag, "_hold_v"}, {31'd0, out_valid}, 32'd1);
                chk({tag, "_hold_d"}, 32'(out_data),      32'(held));
            end
            if (cyc == 1) chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd1);
            start = poke && (cyc == 2);
            if (poke && cyc == 2) begin
                mode = 1'b0; base = b + 7'd33; length = 8'd1;
            end
            if (out_valid && stalls > 0) begin
                out_ready = 1'b0;
                stalls--;
                chk({tag, "_stall_data"}, 32'(out_data), 32'(first));
            end else begin
                out_ready = int'($urandom_range(99)) < rpct;
            end
            hold_chk = out_valid && !out_ready;
            held     = out_data;
            @(negedge CLK);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_done"},    {31'd0, done},      32'd1);
        chk({tag, "_ov_done"}, {31'd0, out_valid}, 32'd0);
        @(negedge CLK);
        chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"},      {31'd0, busy}, 32'd0);
        @(negedge CLK);
        chk({tag, "_still_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_cnt"}, done_cnt - d0,  32'd1);
        chk({tag, "_no_wr"},    wr_log.size(), 32'd0);
        chk({tag, "_nwords"},   rd_log.size(), 32'(int'(l)));
        for (int i = 0; i < int'(l) && i < rd_log.size(); i++) begin
            chk({tag, "_word"}, 32'(rd_log[i]), 32'(ev[i]));
        end
    endtask

    initial begin
        logic [A-1:0] rb;
        logic [A:0]   rl;
        RST = 1'b1; start = 1'b0; mode = 1'b0; base = '0; length = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]       = W'(i);
            model_mem[i] = W'(i);
        end
        #1;
        chk("rst_busy",   {31'd0, busy},       32'd0);
        chk("rst_done",   {31'd0, done},       32'd0);
        chk("rst_inrdy",  {31'd0, in_ready},   32'd0);
        chk("rst_ovalid", {31'd0, out_valid},  32'd0);
        chk("rst_write",  {31'd0, sram_write}, 32'd0);
        chk("rst_odata",  32'(out_data),       32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        write_burst(7'd5,   8'd4, 100, -1, 'hA0, "wr_basic");
        write_burst(7'd126, 8'd4, 100, -1, 'hB0, "wr_wrap");
        write_burst(7'd20,  8'd0, 100, -1, -1,   "wr_len0");
        read_burst (7'd20,  8'd0, 100, 0, 1'b0,  "rd_len0");
        read_burst (7'd10,  8'd3, 100, 2, 1'b0,  "rd_bp");
        read_burst (7'd124, 8'd6, 100, 0, 1'b0,  "rd_wrap");
        write_burst(7'd40,  8'd5, 100, 2, -1,    "wr_rst");
        read_burst (7'd38,  8'd8, 100, 0, 1'b0,  "rd_after_rst");
        read_burst (7'd100, 8'd8, 70,  0, 1'b1,  "rd_poke");

        for (int k = 0; k < 6; k++) begin
            rb = A'($urandom);
            rl = (A+1)'($urandom_range(24, 1));
            write_burst(rb, rl, int'($urandom_range(100, 30)), -1, -1, "wr_rand");
            read_burst(rb - 7'd2, rl + 8'd4, int'($urandom_range(100, 30)),
                       int'($urandom_range(3)), 1'b0, "rd_rand");
        end

        rb = A'($urandom);
        write_burst(rb, 8'd128, 80, -1, -1, "wr_full");
        read_burst(rb + 7'd17, 8'd128, 80, 1, 1'b0, "rd_full");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_burst_ctrl.md
SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 SHALL have parameter A, default 7, meaning SRAM address width (depth 2^A words).
REQ-002 SHALL have parameter W, default 16, meaning word width.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  burst request; sampled only in IDLE.
REQ-006 mode  input  1  0 = write burst (stream into SRAM), 1 = read burst (SRAM to stream).
REQ-007 base  input  A  first SRAM address; captured at start.
REQ-008 length  input  A+1  word count 0..2^A; captured at start.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse when a burst completes.
REQ-011 in_data / in_valid / in_ready  input W / input 1 / output 1  write-burst stream; a word transfers when in_valid and in_ready are both high.
REQ-012 out_data / out_valid / out_ready  output W / output 1 / input 1  read-burst stream; a word transfers when out_valid and out_ready are both high.
REQ-013 sram_address  output  A  SRAM address port.
REQ-014 sram_dataInput  output  W  SRAM write data, equal to in_data.
REQ-015 sram_write  output  1  SRAM write enable.
REQ-016 sram_dataOutput  input  W  SRAM combinational read data for sram_address.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, READ, DONE.
REQ-018 In IDLE with start=1, the block SHALL capture base, length and mode, clear the word counter, and go to WRITE (mode=0) or READ (mode=1); if length=0 it SHALL go directly to DONE.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 sram_address SHALL be (base + counter) mod 2^A; a burst crossing address 2^A-1 SHALL wrap to 0.
REQ-021 In WRITE, in_ready SHALL be 1, and sram_write SHALL equal in_valid combinationally.
REQ-022 In WRITE, each transfer SHALL increment the counter; the transfer of word length-1 SHALL move the FSM to DONE.
REQ-023 in_ready and sram_write SHALL be 0 in every state other than WRITE.
REQ-024 In READ, a W-bit output register SHALL load sram_dataOutput and set out_valid when out_valid=0 or out_ready=1, and words remain unfetched.
REQ-025 First-word latency SHALL be one cycle: out_valid rises in the cycle after the FSM enters READ.
REQ-026 With out_ready held high, READ SHALL sustain one word per cycle.
REQ-027 While out_valid=1 and out_ready=0, out_data SHALL hold stable and the fetch counter SHALL hold.
REQ-028 READ SHALL move to DONE on the transfer of word length-1; out_valid SHALL then be 0.
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-030 When length=2^A, every address SHALL be accessed exactly once.
REQ-031 sram_write SHALL never be high in READ, DONE or IDLE.

Reset
REQ-032 RST=1 SHALL, asynchronously, force IDLE and clear the counter and out_valid.
REQ-033 Under RST, busy, done, in_ready, out_valid and sram_write SHALL be 0, and out_data SHALL be 0.
REQ-034 RST mid-burst SHALL abort the burst without a done pulse; SRAM writes already performed remain.

Structure
REQ-035 Package sram_ctrl_pkg SHALL hold the state enumeration and default A/W constants.
REQ-036 The read output register with its valid/ready logic SHALL be one sub-module, sram_out_stage.
REQ-037 The SRAM itself SHALL stay external to this block.

Verification
REQ-038 Write burst: base=5, length=4, in_data 0xA0..0xA3, in_valid always high -> sram_write high 4 cycles at addresses 5..8, then a done pulse.
REQ-039 Wrap-around: base=126, length=4, A=7 -> addresses 126, 127, 0, 1.
REQ-040 Read with backpressure: memory[i]=i, base=10, length=3, out_ready low for 2 cycles after the first out_valid -> out_data stays 10 until accepted; the sequence 10, 11, 12 arrives with no loss or duplication.
REQ-041 length=0 -> done pulses one cycle after start; sram_write never rises; out_valid never rises.
REQ-042 RST asserted after 2 of 5 write words -> only 2 SRAM writes occur, no done pulse, busy=0 immediately.
REQ-043 start pulsed during a busy read -> ignored; the current burst completes unchanged.
